seg7_monitor: RTL and testbench

- Reads back the 7-segment drive bus produced by the counter/decoder path and recovers the 4-bit hex value (inverse of the 7-segment decoder).
- Debounces the bus, then classifies each new accepted value as a step up, step down or jump relative to the previous one. Flags undecodable patterns.
- Sits on the seg7 bus in system-level test and self-check builds. Clocked by the main clock, not the divided counter clock.

---
 rtl/seg7_monitor_if.sv | 13 +
 rtl/seg7_monitor.sv | 130 +++++++++++++
 tb/tb_seg7_monitor.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_monitor_if.sv
// Bus between the seg7 drive path and the seg7_monitor readback block.
// The master drives the segment lines; the slave (monitor) reports decoded results.
interface seg7_monitor_if;
  logic [6:0] seg7;
  logic [3:0] bin;
  logic       valid;
  logic       invalid;
  logic [1:0] dir;
  logic [7:0] step_err_cnt;

  modport master (output seg7, input bin, valid, invalid, dir, step_err_cnt);
  modport slave  (input seg7, output bin, valid, invalid, dir, step_err_cnt);
endinterface

// File: rtl/seg7_monitor.sv
// Debounces a 7-segment bus, decodes it back to hex and classifies each new value.
// Define SEG7_MON_STATS_EN to build the saturating jump counter on step_err_cnt.
module seg7_monitor #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  seg7_monitor_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, SETTLE, LOCKED} state_t;
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_JUMP = 2'b11
  } dir_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  state_t     state, state_nxt;
  dir_t       dir_q, dir_new;
  logic [6:0] seg_in, s_q, last_pat;
  logic [7:0] cnt;
  logic [3:0] prev, bin_q, dec_val, prev_up, prev_dn;
  logic       valid_q, invalid_q, dec_ok, same, accept;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b1, 4'h0};
      7'h06:   decode = {1'b1, 4'h1};
      7'h5B:   decode = {1'b1, 4'h2};
      7'h4F:   decode = {1'b1, 4'h3};
      7'h66:   decode = {1'b1, 4'h4};
      7'h6D:   decode = {1'b1, 4'h5};
      7'h7D:   decode = {1'b1, 4'h6};
      7'h07:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h6F:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h7C:   decode = {1'b1, 4'hB};
      7'h39:   decode = {1'b1, 4'hC};
      7'h5E:   decode = {1'b1, 4'hD};
      7'h79:   decode = {1'b1, 4'hE};
      7'h71:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  assign seg_in             = SEG_ACTIVE_LOW ? ~bus.seg7 : bus.seg7;
  assign same               = (seg_in == s_q);
  assign {dec_ok, dec_val}  = decode(s_q);
  assign prev_up            = prev + 4'd1;
  assign prev_dn            = prev - 4'd1;

  // Fires only on the edge the run length reaches STABLE_CYCLES, so a held pattern fires once.
  assign accept = same && (s_q != 7'h00) && (cnt == CNT_MAX - 8'd1) && (s_q != last_pat);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    dir_new = DIR_JUMP;
    if (state == EMPTY)        dir_new = DIR_NONE;
    else if (dec_val == prev_up) dir_new = DIR_UP;
    else if (dec_val == prev_dn) dir_new = DIR_DOWN;
    else if (dec_val == prev)    dir_new = DIR_NONE;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept && dec_ok) state_nxt = LOCKED;
      LOCKED:  if (seg_in != last_pat) state_nxt = SETTLE;
      SETTLE:  if (accept || seg_in == last_pat) state_nxt = LOCKED;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      s_q       <= '0;
      cnt       <= '0;
      last_pat  <= '0;
      prev      <= '0;
      bin_q     <= '0;
      dir_q     <= DIR_NONE;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_q       <= seg_in;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      if (!same || seg_in == 7'h00) cnt <= '0;
      else if (cnt != CNT_MAX)      cnt <= cnt + 8'd1;
      if (accept) begin
        last_pat <= s_q;
        if (dec_ok) begin
          bin_q   <= dec_val;
          dir_q   <= dir_new;
          prev    <= dec_val;
          valid_q <= 1'b1;
        end else begin
          invalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bin     = bin_q;
  assign bus.dir     = dir_q;
  assign bus.valid   = valid_q;
  assign bus.invalid = invalid_q;

`ifdef SEG7_MON_STATS_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                   err_q <= '0;
    else if (accept && dec_ok && dir_new == DIR_JUMP && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign bus.step_err_cnt = err_q;
`else
  assign bus.step_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg7_monitor.sv
// Self-checking bench for seg7_monitor: directed scenarios plus randomized traffic
// compared cycle by cycle against a sliding-window reference model.
module tb_seg7_monitor;

  localparam int SC             = 4;
  localparam bit SEG_ACTIVE_LOW = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_monitor_if bus ();

  seg7_monitor #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: acceptance = the last SC samples are one identical non-blank
  // pattern that was not already present one sample earlier, and differs from the
  // last accepted pattern.
  logic [6:0] hist [$];
  logic [6:0] m_last;
  bit         m_have;
  int         m_prev;
  logic [3:0] e_bin;
  logic [1:0] e_dir;
  logic [7:0] e_err;
  bit         e_valid_now, e_invalid_now;
  int         n_valid, n_invalid;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_last = '0; m_have = 0; m_prev = 0;
    e_bin = '0; e_dir = 2'b00; e_err = '0;
    e_valid_now = 0; e_invalid_now = 0;
    n_valid = 0; n_invalid = 0;
  endtask

  task automatic model_edge(input logic [6:0] p);
    int run, idx, d;
    e_valid_now = 0;
    e_invalid_now = 0;
    hist.push_back(p);
    if (hist.size() > SC + 1) void'(hist.pop_front());
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != p) break;
      run++;
    end
    if (run == SC && p != 7'h00 && p != m_last) begin
      m_last = p;
      idx = lookup(p);
      if (idx < 0) begin
        e_invalid_now = 1;
      end else begin
        e_valid_now = 1;
        d = (idx - m_prev + 16) % 16;
        if (!m_have)      e_dir = 2'b00;
        else if (d == 1)  e_dir = 2'b01;
        else if (d == 15) e_dir = 2'b10;
        else if (d == 0)  e_dir = 2'b00;
        else begin
          e_dir = 2'b11;
`ifdef SEG7_MON_STATS_EN
          if (e_err != 8'hFF) e_err = e_err + 8'd1;
`endif
        end
        m_have = 1;
        m_prev = idx;
        e_bin  = 4'(idx);
      end
    end
  endtask

  // Drive one pattern for one clock edge; outputs are observed on the following negedge.
  task automatic step(input logic [6:0] p);
    bus.seg7 = SEG_ACTIVE_LOW ? ~p : p;
    @(posedge clk);
    model_edge(p);
    @(negedge clk);
    if (bus.valid)   n_valid++;
    if (bus.invalid) n_invalid++;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    repeat (n) step(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.seg7 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int first;
    for (int i = 0; i < 6; i++) begin
      bus.seg7 = (i % 2 == 0) ? 7'h3F : 7'h00;
      @(negedge clk);
      tests++;
      if ({bus.bin, bus.valid, bus.invalid, bus.dir, bus.step_err_cnt} !== '0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: bin=%h valid=%b invalid=%b dir=%b err=%0d, expected all 0",
                 i, bus.bin, bus.valid, bus.invalid, bus.dir, bus.step_err_cnt);
      end
    end
    bus.seg7 = 7'h3F;
    rst = 1'b1;
    model_reset();
    first = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step(7'h3F);
      if (bus.valid && first == 0) begin
        first = cyc;
        tests++;
        if (bus.bin !== 4'h0 || bus.dir !== 2'b00) begin
          fails++;
          $display("FAIL reset_first_value: bin=%h dir=%b, expected bin=0 dir=00", bus.bin, bus.dir);
        end
      end
    end
    // Pattern first sampled on edge 1 after release, so the pulse follows edge SC.
    tests++;
    if (first != SC) begin
      fails++;
      $display("FAIL reset_latency: first valid after edge %0d, expected %0d", first, SC);
    end
  endtask

  task automatic test_up_step();
    do_reset();
    hold(7'h3F, 6);
    n_valid = 0; n_invalid = 0;
    hold(7'h06, 4);
    tests++;
    if (n_valid != 1 || bus.bin !== 4'h1 || bus.dir !== 2'b01) begin
      fails++;
      $display("FAIL up_step: pulses=%0d bin=%h dir=%b, expected pulses=1 bin=1 dir=01",
               n_valid, bus.bin, bus.dir);
    end
    hold(7'h06, 8);
    tests++;
    if (n_valid != 1 || n_invalid != 0) begin
      fails++;
      $display("FAIL no_refire: valid pulses=%0d invalid pulses=%0d, expected 1 and 0", n_valid, n_invalid);
    end
  endtask

  task automatic test_glitch();
    n_valid = 0; n_invalid = 0;
    hold(7'h5B, SC - 1);
    hold(7'h06, 6);
    tests++;
    if (n_valid != 0 || n_invalid != 0 || bus.bin !== 4'h1) begin
      fails++;
      $display("FAIL glitch: valid=%0d invalid=%0d bin=%h, expected 0 0 1", n_valid, n_invalid, bus.bin);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    hold(7'h71, 6);
    hold(7'h3F, 6);
    tests++;
    if (bus.dir !== 2'b01 || bus.bin !== 4'h0) begin
      fails++;
      $display("FAIL wrap_up: dir=%b bin=%h, expected dir=01 bin=0", bus.dir, bus.bin);
    end
    hold(7'h71, 6);
    tests++;
    if (bus.dir !== 2'b10 || bus.bin !== 4'hF) begin
      fails++;
      $display("FAIL wrap_down: dir=%b bin=%h, expected dir=10 bin=f", bus.dir, bus.bin);
    end
  endtask

  task automatic test_jump_invalid();
    logic [7:0] exp_err;
`ifdef SEG7_MON_STATS_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    do_reset();
    hold(7'h3F, 6);
    hold(7'h66, 6);
    tests++;
    if (bus.dir !== 2'b11 || bus.bin !== 4'h4 || bus.step_err_cnt !== exp_err) begin
      fails++;
      $display("FAIL jump: dir=%b bin=%h err=%0d, expected dir=11 bin=4 err=%0d",
               bus.dir, bus.bin, bus.step_err_cnt, exp_err);
    end
    n_valid = 0; n_invalid = 0;
    hold(7'h01, 10);
    tests++;
    if (n_invalid != 1 || n_valid != 0 || bus.bin !== 4'h4 || bus.dir !== 2'b11) begin
      fails++;
      $display("FAIL invalid: invalid=%0d valid=%0d bin=%h dir=%b, expected 1 0 4 11",
               n_invalid, n_valid, bus.bin, bus.dir);
    end
    hold(7'h6D, 6);
    tests++;
    if (bus.dir !== 2'b01 || bus.bin !== 4'h5) begin
      fails++;
      $display("FAIL after_invalid: dir=%b bin=%h, expected dir=01 bin=5", bus.dir, bus.bin);
    end
  endtask

  task automatic test_blank_reset();
    int first;
    n_valid = 0; n_invalid = 0;
    hold(7'h00, 20);
    tests++;
    if (n_valid != 0 || n_invalid != 0 || bus.bin !== 4'h5) begin
      fails++;
      $display("FAIL blank: valid=%0d invalid=%0d bin=%h, expected 0 0 5", n_valid, n_invalid, bus.bin);
    end
    hold(7'h4F, 2);
    rst = 1'b0;
    #1;
    tests++;
    if ({bus.bin, bus.valid, bus.invalid, bus.dir, bus.step_err_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset: bin=%h valid=%b invalid=%b dir=%b err=%0d, expected all 0",
               bus.bin, bus.valid, bus.invalid, bus.dir, bus.step_err_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    first = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      step(7'h4F);
      if (bus.valid && first == 0) first = cyc;
    end
    tests++;
    if (first != SC || n_valid != 1 || bus.bin !== 4'h3) begin
      fails++;
      $display("FAIL settle_after_reset: first=%0d pulses=%0d bin=%h, expected %0d 1 3",
               first, n_valid, bus.bin, SC);
    end
  endtask

  task automatic test_random();
    int r, len, shown;
    logic [6:0] p;
    shown = 0;
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      p = 7'h00;
      else if (r == 1) p = 7'($urandom_range(1, 127));
      else if (r <= 5) p = seg_tab[(m_prev + ((r % 2) ? 1 : 15)) % 16];
      else             p = seg_tab[$urandom_range(0, 15)];
      len = $urandom_range(1, SC + 2);
      for (int k = 0; k < len; k++) begin
        step(p);
        tests++;
        if (bus.valid !== e_valid_now || bus.invalid !== e_invalid_now || bus.bin !== e_bin ||
            bus.dir !== e_dir || bus.step_err_cnt !== e_err || (bus.valid && bus.invalid)) begin
          fails++;
          if (shown < 20) begin
            shown++;
            $display("FAIL random seg %0d pat %h: got v=%b i=%b bin=%h dir=%b err=%0d, expected v=%b i=%b bin=%h dir=%b err=%0d",
                     seg, p, bus.valid, bus.invalid, bus.bin, bus.dir, bus.step_err_cnt,
                     e_valid_now, e_invalid_now, e_bin, e_dir, e_err);
          end
        end
      end
    end
  endtask

  initial begin
    bus.seg7 = '0;
    model_reset();
    test_reset();
    test_up_step();
    test_glitch();
    test_wrap();
    test_jump_invalid();
    test_blank_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
